// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline. It tracks EX/MEM/WB
// destination metadata and drives stall/bubble/flush, forwarding, ID bypass and perf counters.
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2,
  input  logic                      id_uses_rs1,
  input  logic                      id_uses_rs2,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd,
  input  logic                      id_reg_write,
  input  logic                      id_mem_read,
  input  logic                      ex_branch_taken,
  input  logic                      mem_busy,
  output logic                      pc_stall,
  output logic                      if_id_stall,
  output logic                      id_ex_bubble,
  output logic                      if_id_flush,
  output logic [1:0]                fwd_a,
  output logic [1:0]                fwd_b,
  output logic                      id_byp_rs1,
  output logic                      id_byp_rs2,
  output logic                      wb_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] wb_rd,
  output logic [CNT_WIDTH-1:0]      stall_cnt,
  output logic [CNT_WIDTH-1:0]      flush_cnt
);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_t;

  typedef struct packed {
    logic valid;
    reg_t rd;
    reg_t rs1;
    reg_t rs2;
    logic reg_write;
    logic mem_read;
    logic uses_rs1;
    logic uses_rs2;
  } ex_stage_t;

  // MEM and WB only keep the fields something downstream still consumes.
  typedef struct packed {
    logic valid;
    reg_t rd;
    logic reg_write;
  } dst_stage_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_TWO = CNT_WIDTH'(2);
  localparam reg_t                 REG_X0  = '0;

  ex_stage_t  ex_q;
  ex_stage_t  ex_d;
  dst_stage_t mem_q;
  dst_stage_t wb_q;
  logic       mem_load_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q;
  logic [CNT_WIDTH-1:0] flush_cnt_q;

  logic rs1_hit;
  logic rs2_hit;
  logic lu;

  always_comb begin
    rs1_hit = id_uses_rs1 && (id_rs1 == ex_q.rd);
    rs2_hit = id_uses_rs2 && (id_rs2 == ex_q.rd);
    lu      = ex_q.valid && ex_q.mem_read && ex_q.reg_write && id_valid && (rs1_hit || rs2_hit);
  end

  // Freeze beats redirect beats load-use; a taken branch discards the ID instruction anyway.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (mem_busy) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
    end else if (lu) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_bubble = 1'b1;
    end
  end

  // Empty slots are all-zero so stale source fields can never match a producer.
  always_comb begin
    ex_d = '0;
    if (id_valid && !id_ex_bubble) begin
      ex_d.valid     = 1'b1;
      ex_d.rd        = id_rd;
      ex_d.rs1       = id_rs1;
      ex_d.rs2       = id_rs2;
      ex_d.reg_write = id_reg_write && (id_rd != REG_X0);
      ex_d.mem_read  = id_mem_read;
      ex_d.uses_rs1  = id_uses_rs1;
      ex_d.uses_rs2  = id_uses_rs2;
    end
  end

  function automatic logic [1:0] fwd_sel(input logic       uses,
                                         input reg_t       src,
                                         input dst_stage_t mem,
                                         input logic       mem_load,
                                         input dst_stage_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem.valid && mem.reg_write && !mem_load && uses && (mem.rd == src)) begin
      sel = 2'b01;
    end else if (wb.valid && wb.reg_write && (wb.rd == src)) begin
      sel = 2'b10;
    end
    return sel;
  endfunction

  assign fwd_a = fwd_sel(ex_q.uses_rs1, ex_q.rs1, mem_q, mem_load_q, wb_q);
  assign fwd_b = fwd_sel(ex_q.uses_rs2, ex_q.rs2, mem_q, mem_load_q, wb_q);

  // The register file writes on the edge while ID reads combinationally, so WB is bypassed.
  assign id_byp_rs1 = wb_q.valid && wb_q.reg_write && id_uses_rs1 && (id_rs1 == wb_q.rd);
  assign id_byp_rs2 = wb_q.valid && wb_q.reg_write && id_uses_rs2 && (id_rs2 == wb_q.rd);

  assign wb_reg_write = wb_q.valid && wb_q.reg_write;
  assign wb_rd        = wb_q.rd;
  assign stall_cnt    = stall_cnt_q;
  assign flush_cnt    = flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      mem_load_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else if (!mem_busy) begin
      wb_q       <= mem_q;
      mem_q      <= '{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write};
      mem_load_q <= ex_q.mem_read;
      ex_q       <= ex_d;
      if (ex_branch_taken) begin
        if (flush_cnt_q >= CNT_MAX - CNT_ONE) begin
          flush_cnt_q <= CNT_MAX;
        end else begin
          flush_cnt_q <= flush_cnt_q + CNT_TWO;
        end
      end else if (lu) begin
        if (stall_cnt_q != CNT_MAX) begin
          stall_cnt_q <= stall_cnt_q + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic against an
// in-flight instruction model; a 3-bit-counter instance exposes counter saturation quickly.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_uses_rs1, id_uses_rs2, id_reg_write, id_mem_read;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic ex_branch_taken, mem_busy;

  logic pc_stall, if_id_stall, id_ex_bubble, if_id_flush;
  logic [1:0] fwd_a, fwd_b;
  logic id_byp_rs1, id_byp_rs2, wb_reg_write;
  logic [4:0] wb_rd;
  logic [15:0] stall_cnt, flush_cnt;

  logic s_pc_stall, s_if_id_stall, s_id_ex_bubble, s_if_id_flush;
  logic [1:0] s_fwd_a, s_fwd_b;
  logic s_id_byp_rs1, s_id_byp_rs2, s_wb_reg_write;
  logic [4:0] s_wb_rd;
  logic [2:0] s_stall_cnt, s_flush_cnt;

  int errors = 0;
  int checks = 0;

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_bubble(id_ex_bubble),
    .if_id_flush(if_id_flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .id_byp_rs1(id_byp_rs1), .id_byp_rs2(id_byp_rs2),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(3)) dut_s (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_busy(mem_busy),
    .pc_stall(s_pc_stall), .if_id_stall(s_if_id_stall), .id_ex_bubble(s_id_ex_bubble),
    .if_id_flush(s_if_id_flush), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .id_byp_rs1(s_id_byp_rs1), .id_byp_rs2(s_id_byp_rs2),
    .wb_reg_write(s_wb_reg_write), .wb_rd(s_wb_rd),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the three most recent issue slots, youngest first (EX, MEM, WB).
  typedef struct packed {
    logic v; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
    logic wr; logic ld; logic u1; logic u2;
  } ins_t;

  ins_t pipe_q[$];
  int   m_stall = 0;
  int   m_flush = 0;

  function automatic bit writes(input ins_t e, input logic [4:0] r);
    return e.v && e.wr && (e.rd != 5'd0) && (e.rd == r);
  endfunction

  function automatic bit m_lu();
    ins_t e = pipe_q[0];
    return e.ld && id_valid && ((id_uses_rs1 && writes(e, id_rs1)) || (id_uses_rs2 && writes(e, id_rs2)));
  endfunction

  // Nearest older producer wins, except a load one slot ahead cannot deliver yet.
  function automatic logic [1:0] m_fwd(input logic used, input logic [4:0] src);
    if (used && writes(pipe_q[1], src) && !pipe_q[1].ld) return 2'b01;
    if (writes(pipe_q[2], src)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : 16'(v);
  endfunction

  function automatic logic [2:0] sat3(input int v);
    return (v > 7) ? 3'd7 : 3'(v);
  endfunction

  task automatic model_reset();
    pipe_q.delete();
    repeat (3) pipe_q.push_back('0);
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_step();
    ins_t n;
    bit   lu;
    if (rst) begin
      model_reset();
    end else if (!mem_busy) begin
      lu = m_lu();
      n  = '0;
      if (id_valid && !ex_branch_taken && !lu)
        n = '{v: 1'b1, rd: id_rd, rs1: id_rs1, rs2: id_rs2, wr: id_reg_write,
              ld: id_mem_read, u1: id_uses_rs1, u2: id_uses_rs2};
      pipe_q.push_front(n);
      void'(pipe_q.pop_back());
      if (ex_branch_taken) m_flush += 2;
      else if (lu) m_stall += 1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    id_rd = 0; id_reg_write = 0; id_mem_read = 0; ex_branch_taken = 0; mem_busy = 0;
  endtask

  task automatic issue(input int rd, input int rs1, input int rs2,
                       input bit u1, input bit u2, input bit wr, input bit ld);
    id_valid = 1; id_rd = 5'(rd); id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_reg_write = wr; id_mem_read = ld;
    ex_branch_taken = 0; mem_busy = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    @(negedge clk);
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_byp_rs1, id_byp_rs2, wb_reg_write} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_byp_rs1, id_byp_rs2, wb_reg_write}); end
    checks++; if (fwd_a !== 2'b00) begin errors++; $display("FAIL reset_fwd_a: got %b want 00", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL reset_fwd_b: got %b want 00", fwd_b); end
    checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd: got %0d want 0", wb_rd); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++; if (flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_flush_cnt: got %0d want 0", flush_cnt); end
    checks++; if ({s_stall_cnt, s_flush_cnt} !== 6'd0) begin errors++; $display("FAIL reset_small_cnts: got %b want 0", {s_stall_cnt, s_flush_cnt}); end
  endtask

  task automatic test_load_use();
    issue(5, 1, 0, 1, 0, 1, 1);
    @(negedge clk);
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b000) begin errors++; $display("FAIL lu_lw_nostall: got %b want 000", {pc_stall, if_id_stall, id_ex_bubble}); end
    tick();
    issue(6, 5, 7, 1, 1, 1, 0);
    @(negedge clk);
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b1110) begin errors++; $display("FAIL lu_stall: got %b want 1110", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush}); end
    tick();
    @(negedge clk);
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b000) begin errors++; $display("FAIL lu_single_stall: got %b want 000", {pc_stall, if_id_stall, id_ex_bubble}); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL lu_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
    set_idle();
    @(negedge clk);
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL lu_fwd_a: got %b want 10", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL lu_fwd_b: got %b want 00", fwd_b); end
    tick();
  endtask

  task automatic test_forwarding();
    issue(3, 1, 2, 1, 1, 1, 0);
    tick();
    issue(4, 3, 3, 1, 1, 1, 0);
    @(negedge clk);
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL fwd_alu_nostall: got %b want 0", pc_stall); end
    tick();
    set_idle();
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin errors++; $display("FAIL fwd_alu_ab: got %b want 0101", {fwd_a, fwd_b}); end
    tick();
    issue(3, 1, 2, 1, 1, 1, 0);
    tick();
    issue(3, 0, 0, 1, 0, 1, 0);
    tick();
    issue(9, 3, 0, 1, 1, 1, 0);
    tick();
    set_idle();
    @(negedge clk);
    checks++; if (fwd_a !== 2'b01) begin errors++; $display("FAIL fwd_mem_priority: got %b want 01", fwd_a); end
    checks++; if (fwd_b !== 2'b00) begin errors++; $display("FAIL fwd_x0_src: got %b want 00", fwd_b); end
    checks++; if ({wb_reg_write, wb_rd} !== {1'b1, 5'd3}) begin errors++; $display("FAIL wb_port: got %b/%0d want 1/3", wb_reg_write, wb_rd); end
    tick();
    issue(10, 3, 3, 1, 1, 1, 0);
    @(negedge clk);
    checks++; if ({id_byp_rs1, id_byp_rs2} !== 2'b11) begin errors++; $display("FAIL id_bypass: got %b want 11", {id_byp_rs1, id_byp_rs2}); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_branch_lu();
    issue(5, 1, 0, 1, 0, 1, 1);
    tick();
    issue(6, 5, 7, 1, 1, 1, 0);
    ex_branch_taken = 1;
    @(negedge clk);
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b0011) begin errors++; $display("FAIL branch_ctrl: got %b want 0011", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush}); end
    tick();
    set_idle();
    @(negedge clk);
    checks++; if (flush_cnt !== 16'd2) begin errors++; $display("FAIL branch_flush_cnt: got %0d want 2", flush_cnt); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL branch_stall_cnt: got %0d want 1", stall_cnt); end
    tick();
  endtask

  task automatic test_mem_busy();
    issue(5, 1, 0, 1, 0, 1, 1);
    tick();
    issue(6, 5, 7, 1, 1, 1, 0);
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b1100) begin errors++; $display("FAIL busy_ctrl[%0d]: got %b want 1100", i, {pc_stall, if_id_stall, id_ex_bubble, if_id_flush}); end
      checks++; if ({stall_cnt, flush_cnt} !== {16'd1, 16'd2}) begin errors++; $display("FAIL busy_cnt_hold[%0d]: got %0d/%0d want 1/2", i, stall_cnt, flush_cnt); end
      tick();
    end
    mem_busy = 0;
    @(negedge clk);
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble} !== 3'b111) begin errors++; $display("FAIL busy_release_stall: got %b want 111", {pc_stall, if_id_stall, id_ex_bubble}); end
    tick();
    @(negedge clk);
    checks++; if ({pc_stall, id_ex_bubble} !== 2'b00) begin errors++; $display("FAIL busy_one_stall: got %b want 00", {pc_stall, id_ex_bubble}); end
    checks++; if (stall_cnt !== 16'd2) begin errors++; $display("FAIL busy_stall_cnt: got %0d want 2", stall_cnt); end
    tick();
    set_idle();
    @(negedge clk);
    checks++; if (fwd_a !== 2'b10) begin errors++; $display("FAIL busy_fwd_a: got %b want 10", fwd_a); end
    tick();
  endtask

  task automatic test_x0();
    issue(0, 0, 0, 1, 0, 1, 0);
    tick();
    issue(1, 0, 0, 1, 1, 1, 0);
    @(negedge clk);
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL x0_nostall: got %b want 0", pc_stall); end
    tick();
    set_idle();
    @(negedge clk);
    checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin errors++; $display("FAIL x0_nofwd: got %b want 0000", {fwd_a, fwd_b}); end
    tick();
    @(negedge clk);
    checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL x0_wb_write: got %b want 0", wb_reg_write); end
    issue(0, 1, 0, 1, 0, 1, 1);
    tick();
    issue(2, 0, 0, 1, 1, 1, 0);
    @(negedge clk);
    checks++; if (pc_stall !== 1'b0) begin errors++; $display("FAIL x0_load_nostall: got %b want 0", pc_stall); end
    tick();
    set_idle();
    tick();
  endtask

  task automatic test_saturation();
    // A chained lw x5,0(x5) stalls every second cycle.
    for (int i = 0; i < 24; i++) begin
      issue(5, 5, 0, 1, 0, 1, 1);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      set_idle();
      ex_branch_taken = 1;
      tick();
    end
    set_idle();
    @(negedge clk);
    checks++; if (s_stall_cnt !== 3'd7) begin errors++; $display("FAIL sat_small_stall: got %0d want 7", s_stall_cnt); end
    checks++; if (s_flush_cnt !== 3'd7) begin errors++; $display("FAIL sat_small_flush: got %0d want 7", s_flush_cnt); end
    checks++; if (stall_cnt !== sat16(m_stall)) begin errors++; $display("FAIL sat_wide_stall: got %0d want %0d", stall_cnt, sat16(m_stall)); end
    checks++; if (flush_cnt !== 16'd12) begin errors++; $display("FAIL sat_wide_flush: got %0d want 12", flush_cnt); end
    tick();
  endtask

  task automatic test_reset_mid_stall();
    issue(5, 1, 0, 1, 0, 1, 1);
    tick();
    issue(6, 5, 7, 1, 1, 1, 0);
    @(negedge clk);
    checks++; if (pc_stall !== 1'b1) begin errors++; $display("FAIL rms_setup: got %b want 1", pc_stall); end
    rst = 1;
    tick();
    @(negedge clk);
    checks++; if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== 4'b0000) begin errors++; $display("FAIL rms_ctrl: got %b want 0000", {pc_stall, if_id_stall, id_ex_bubble, if_id_flush}); end
    checks++; if ({stall_cnt, flush_cnt} !== 32'd0) begin errors++; $display("FAIL rms_cnts: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    rst = 0;
    set_idle();
    tick();
  endtask

  task automatic test_random();
    bit hold = 0;
    logic [3:0] e_ctrl;
    bit lu;
    for (int c = 0; c < 600; c++) begin
      if (!hold) begin
        id_valid     = ($urandom_range(0, 7) != 0);
        id_rd        = 5'($urandom_range(0, 7));
        id_rs1       = 5'($urandom_range(0, 7));
        id_rs2       = 5'($urandom_range(0, 7));
        id_uses_rs1  = 1'($urandom_range(0, 1));
        id_uses_rs2  = 1'($urandom_range(0, 1));
        id_reg_write = ($urandom_range(0, 4) != 0);
        id_mem_read  = ($urandom_range(0, 2) == 0);
      end
      ex_branch_taken = ($urandom_range(0, 9) == 0);
      mem_busy        = ($urandom_range(0, 9) == 0);
      lu = m_lu();
      e_ctrl[3] = mem_busy || (!ex_branch_taken && lu);
      e_ctrl[2] = e_ctrl[3];
      e_ctrl[1] = !mem_busy && (ex_branch_taken || lu);
      e_ctrl[0] = !mem_busy && ex_branch_taken;
      @(negedge clk);
      checks++; if ({pc_stall, if_id_stall, id_ex_bubble, if_id_flush} !== e_ctrl) begin errors++; $display("FAIL rnd_ctrl c%0d: got %b want %b", c, {pc_stall, if_id_stall, id_ex_bubble, if_id_flush}, e_ctrl); end
      checks++; if (fwd_a !== m_fwd(pipe_q[0].u1, pipe_q[0].rs1)) begin errors++; $display("FAIL rnd_fwd_a c%0d: got %b want %b", c, fwd_a, m_fwd(pipe_q[0].u1, pipe_q[0].rs1)); end
      checks++; if (fwd_b !== m_fwd(pipe_q[0].u2, pipe_q[0].rs2)) begin errors++; $display("FAIL rnd_fwd_b c%0d: got %b want %b", c, fwd_b, m_fwd(pipe_q[0].u2, pipe_q[0].rs2)); end
      checks++; if ({id_byp_rs1, id_byp_rs2} !== {id_uses_rs1 && writes(pipe_q[2], id_rs1), id_uses_rs2 && writes(pipe_q[2], id_rs2)}) begin
        errors++; $display("FAIL rnd_byp c%0d: got %b", c, {id_byp_rs1, id_byp_rs2}); end
      checks++; if ({wb_reg_write, wb_rd} !== {writes(pipe_q[2], pipe_q[2].rd), pipe_q[2].rd}) begin
        errors++; $display("FAIL rnd_wb c%0d: got %b/%0d want rd %0d", c, wb_reg_write, wb_rd, pipe_q[2].rd); end
      checks++; if ({stall_cnt, flush_cnt} !== {sat16(m_stall), sat16(m_flush)}) begin
        errors++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d/%0d", c, stall_cnt, flush_cnt, m_stall, m_flush); end
      checks++; if ({s_stall_cnt, s_flush_cnt} !== {sat3(m_stall), sat3(m_flush)}) begin
        errors++; $display("FAIL rnd_small_cnt c%0d: got %0d/%0d want %0d/%0d", c, s_stall_cnt, s_flush_cnt, sat3(m_stall), sat3(m_flush)); end
      hold = e_ctrl[2];
      tick();
    end
  endtask

  initial begin
    set_idle();
    rst = 1;
    model_reset();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_lu();
    test_mem_busy();
    test_x0();
    test_saturation();
    test_reset_mid_stall();
    set_idle();
    rst = 1;
    tick();
    rst = 0;
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard and sequencing controller for the 5-stage RISC-V core (IF, ID, EX, MEM, WB).
- Keeps a shadow pipeline of destination-register metadata for the EX, MEM and WB stages.
- From that state it generates stall, bubble and flush controls for the fetch and decode stages, and EX-stage operand forwarding selects.
- It also provides ID-stage write-through bypass for the register file, and saturating performance counters for stalls and flushes.

Parameters:
REG_ADDR_WIDTH, 5, register address width
CNT_WIDTH, 16, width of each performance counter

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  ID stage holds a real instruction
id_rs1  input  REG_ADDR_WIDTH  source register 1 of the ID instruction
id_rs2  input  REG_ADDR_WIDTH  source register 2 of the ID instruction
id_uses_rs1  input  1  ID instruction reads rs1
id_uses_rs2  input  1  ID instruction reads rs2
id_rd  input  REG_ADDR_WIDTH  destination register of the ID instruction
id_reg_write  input  1  ID instruction writes rd
id_mem_read  input  1  ID instruction is a load
ex_branch_taken  input  1  EX resolved a taken branch or JAL this cycle
mem_busy  input  1  data memory not ready; freezes the whole pipeline
pc_stall  output  1  hold PC
if_id_stall  output  1  hold the IF/ID register
id_ex_bubble  output  1  load a NOP into the ID/EX register
if_id_flush  output  1  clear IF/ID to a NOP
fwd_a  output  2  EX operand A select: 00 = register file, 01 = MEM result, 10 = WB result
fwd_b  output  2  EX operand B select, same encoding as fwd_a
id_byp_rs1  output  1  ID rs1 must take the WB write data (same-cycle write)
id_byp_rs2  output  1  ID rs2 must take the WB write data
wb_reg_write  output  1  write enable for the register file, from the WB shadow stage
wb_rd  output  REG_ADDR_WIDTH  register file write address, from the WB shadow stage
stall_cnt  output  CNT_WIDTH  count of load-use stall cycles
flush_cnt  output  CNT_WIDTH  count of flushed (bubbled) instruction slots

Behaviour:
Shadow state
- Three shadow stages: EX, MEM, WB.
- Each stage holds: valid, rd, reg_write, mem_read, rs1, rs2, uses_rs1, uses_rs2.
- Any stage with rd == 0 is treated as reg_write = 0.

Reset
- All shadow stages become invalid.
- All counters reset to 0.
- All combinational outputs evaluate to 0 (fwd_a and fwd_b to 00) while shadow state is invalid and inputs are idle.

Load-use hazard
- `lu` = EX.valid & EX.mem_read & EX.reg_write & id_valid & ((id_uses_rs1 & id_rs1 == EX.rd) | (id_uses_rs2 & id_rs2 == EX.rd)).

Control outputs, evaluated in priority order, all combinational:
1. mem_busy = 1:
   - pc_stall = if_id_stall = 1; bubble = flush = 0.
   - Shadow stages hold; counters hold.
2. ex_branch_taken = 1:
   - if_id_flush = 1, id_ex_bubble = 1, pc_stall = 0.
   - flush_cnt += 2 (saturating).
   - The load-use stall is suppressed, because the ID instruction is discarded.
3. lu = 1:
   - pc_stall = if_id_stall = id_ex_bubble = 1.
   - stall_cnt += 1 (saturating).
   - Latency is exactly one stall cycle per load-use hazard.
4. Otherwise all controls are 0.

Shadow update on each rising edge when not frozen by mem_busy:
- WB <= MEM; MEM <= EX.
- EX <= ID fields when id_valid and there is no bubble; otherwise EX <= invalid.

Forwarding
- fwd_a = 01 if MEM.valid & MEM.reg_write & !MEM.mem_read & EX.uses_rs1 & MEM.rd == EX.rs1.
- Else fwd_a = 10 if WB.valid & WB.reg_write & WB.rd == EX.rs1.
- Else fwd_a = 00.
- fwd_b follows the same rules using rs2.
- MEM has priority over WB (youngest producer wins).
- A load in MEM is never forwarded from MEM; the load-use stall guarantees it is in WB by then.

ID bypass
- id_byp_rsN = WB.valid & WB.reg_write & id_uses_rsN & id_rsN == WB.rd.
- This is required because the register file writes on the clock edge while ID reads combinationally.

Register file write port
- wb_reg_write = WB.valid & WB.reg_write; wb_rd = WB.rd.

Counters
- Both counters saturate at all-ones and never wrap.

Reset mid-stall
- rst has priority over everything.
- On the next cycle all stall, bubble and flush outputs are 0.

Test Plan:
1. rst=1 for 2 cycles, then idle -> all outputs 0, fwd_a = fwd_b = 00, stall_cnt = flush_cnt = 0.
2. `lw x5` then `add x6,x5,x7` issued back-to-back ->
   - one cycle of pc_stall = if_id_stall = id_ex_bubble = 1; stall_cnt = 1.
   - When the add reaches EX, fwd_a = 10.
3. `add x3,x1,x2` then `sub x4,x3,x3` -> no stall; when the sub is in EX, fwd_a = fwd_b = 01.
   - `add x3`, then `addi x3`, then `or x9,x3,x0` -> for the or in EX, fwd_a = 01 (MEM priority).
4. ex_branch_taken=1 in the same cycle as a load-use match -> if_id_flush = id_ex_bubble = 1, pc_stall = 0, flush_cnt += 2, stall_cnt unchanged.
5. mem_busy=1 for 3 cycles during a load-use hazard -> shadow and counters frozen; after release exactly one stall cycle occurs.
6. `addi x0,x0,1` followed by `add x1,x0,x0` -> no forwarding, no stall, wb_reg_write = 0 for the x0 writer.
   - Also force stall_cnt to all-ones (0xFFFF) then trigger one more stall -> stays 0xFFFF.
